cgra_array_ctrl: RTL and testbench

- Execution sequencer for the 3x2 torus PE array.
- Accepts a start request from the host-side interface and latches the instruction count.
- Steps a shared instruction-memory address across all PEs, one instruction per cycle, and drives PE_Array_Busy for the whole run.
- Reports completion through a level Done / Start handshake and counts run cycles for performance readout.

---
 rtl/cgra_array_ctrl.sv | 156 +++++++++++++++
 tb/tb_cgra_array_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_array_ctrl.sv
// Execution sequencer for the 3x2 torus PE array: fetches instructions,
// keeps the array busy through fill/run/drain, and reports Done with cycle count.
module cgra_array_ctrl #(
    parameter int IADDR_WIDTH  = 10,
    parameter int FILL_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic                   Start,
    input  logic [IADDR_WIDTH:0]   Inst_Num,
    input  logic                   Stall,
    output logic [IADDR_WIDTH-1:0] Inst_Addr,
    output logic                   Inst_Rd_En,
    output logic                   PE_Array_Busy,
    output logic                   Done,
    output logic [CNT_WIDTH-1:0]   Cycle_Cnt
);

    localparam int NW     = IADDR_WIDTH + 1;
    localparam int PH_MAX = (FILL_CYCLES > DRAIN_CYCLES) ? FILL_CYCLES : DRAIN_CYCLES;
    localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX + 1);
    localparam logic [NW-1:0] N_MAX = NW'(1) << IADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [NW-1:0]          n_q, n_d;
    logic [NW-1:0]          issue_q, issue_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [IADDR_WIDTH-1:0] addr_q, addr_d;
    logic                   rd_en_q, rd_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CNT_WIDTH-1:0]   cyc_q, cyc_d;

    logic [NW-1:0]          n_clamp;
    logic [NW-1:0]          n_m1;
    logic [IADDR_WIDTH-1:0] last_addr;

    assign n_clamp   = (Inst_Num > N_MAX) ? N_MAX : Inst_Num;
    assign n_m1      = n_q - NW'(1);
    assign last_addr = n_m1[IADDR_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        issue_d = issue_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        rd_en_d = rd_en_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cyc_d   = cyc_q;

        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                rd_en_d = 1'b0;
                done_d  = 1'b0;
                if (Start) begin
                    n_d     = n_clamp;
                    addr_d  = '0;
                    cyc_d   = '0;
                    phase_d = '0;
                    issue_d = '0;
                    busy_d  = 1'b1;
                    if (n_clamp != '0) begin
                        rd_en_d = 1'b1;
                        state_d = (FILL_CYCLES == 0) ? RUN : FILL;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            FILL, RUN, DRAIN: begin
                if (Stall) begin
                    // Frozen cycle: nothing advances, array and fetch are gated off.
                    busy_d  = 1'b0;
                    rd_en_d = 1'b0;
                end else begin
                    busy_d = 1'b1;
                    if (cyc_q != '1) cyc_d = cyc_q + CNT_WIDTH'(1);
                    rd_en_d = 1'b0;
                    if (state_q != DRAIN && addr_q != last_addr) begin
                        addr_d  = addr_q + IADDR_WIDTH'(1);
                        rd_en_d = 1'b1;
                    end
                    if (state_q == FILL) begin
                        if (phase_q == PH_W'(FILL_CYCLES - 1)) begin
                            state_d = RUN;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end else if (state_q == RUN) begin
                        if (issue_q == n_m1) begin
                            state_d = DRAIN;
                            phase_d = '0;
                        end else begin
                            issue_d = issue_q + NW'(1);
                        end
                    end else begin
                        if (phase_q == PH_W'(DRAIN_CYCLES - 1)) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                // Start must drop before another run can be accepted.
                if (!Start) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            n_q     <= '0;
            issue_q <= '0;
            phase_q <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            issue_q <= issue_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
        end
    end

    assign Inst_Addr     = addr_q;
    assign Inst_Rd_En    = rd_en_q;
    assign PE_Array_Busy = busy_q;
    assign Done          = done_q;
    assign Cycle_Cnt     = cyc_q;

endmodule

// File: tb/tb_cgra_array_ctrl.sv
// Directed bench for cgra_array_ctrl: default-size instance plus a 4-bit
// address instance for the maximum-length and clamp cases.
module tb_cgra_array_ctrl;

    localparam int AW  = 10;
    localparam int NW  = AW + 1;
    localparam int SAW = 4;
    localparam int SNW = SAW + 1;
    localparam int CW  = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [NW-1:0] inst_num = '0;
    logic [AW-1:0] inst_addr;
    logic          rd_en, busy, done;
    logic [CW-1:0] cyc;

    logic           s_start = 1'b0;
    logic [SNW-1:0] s_inst_num = '0;
    logic [SAW-1:0] s_addr;
    logic           s_rd_en, s_busy, s_done;
    logic [CW-1:0]  s_cyc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cgra_array_ctrl dut (
        .Clk(clk), .Resetn(rst_n), .Start(start), .Inst_Num(inst_num), .Stall(stall),
        .Inst_Addr(inst_addr), .Inst_Rd_En(rd_en), .PE_Array_Busy(busy),
        .Done(done), .Cycle_Cnt(cyc)
    );

    cgra_array_ctrl #(.IADDR_WIDTH(SAW)) dut_s (
        .Clk(clk), .Resetn(rst_n), .Start(s_start), .Inst_Num(s_inst_num), .Stall(stall),
        .Inst_Addr(s_addr), .Inst_Rd_En(s_rd_en), .PE_Array_Busy(s_busy),
        .Done(s_done), .Cycle_Cnt(s_cyc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_checks++; if (inst_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", inst_addr); end
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (cyc !== '0) begin n_fail++; $display("FAIL reset_cyc got %0d want 0", cyc); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic;
        int ea;
        inst_num = NW'(5);
        start = 1'b1;
        tick();
        for (int k = 1; k <= 11; k++) begin
            ea = (k - 1 < 4) ? k - 1 : 4;
            n_checks++; if (busy !== (k <= 10)) begin n_fail++; $display("FAIL basic_busy k=%0d got %b want %b", k, busy, (k <= 10)); end
            n_checks++; if (inst_addr !== AW'(ea)) begin n_fail++; $display("FAIL basic_addr k=%0d got %0d want %0d", k, inst_addr, ea); end
            n_checks++; if (rd_en !== (k <= 5)) begin n_fail++; $display("FAIL basic_rd_en k=%0d got %b want %b", k, rd_en, (k <= 5)); end
            n_checks++; if (done !== (k == 11)) begin n_fail++; $display("FAIL basic_done k=%0d got %b want %b", k, done, (k == 11)); end
            if (k == 3) inst_num = NW'(1);
            if (k < 11) tick();
        end
        n_checks++; if (cyc !== CW'(10)) begin n_fail++; $display("FAIL basic_cyc got %0d want 10", cyc); end
        start = 1'b0;
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_drop got %b want 0", done); end
        n_checks++; if (cyc !== CW'(10)) begin n_fail++; $display("FAIL basic_cyc_hold got %0d want 10", cyc); end
    endtask

    task automatic test_zero;
        inst_num = '0;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (busy !== (k <= 3)) begin n_fail++; $display("FAIL zero_busy k=%0d got %b want %b", k, busy, (k <= 3)); end
            n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL zero_rd_en k=%0d got %b want 0", k, rd_en); end
            n_checks++; if (done !== (k == 4)) begin n_fail++; $display("FAIL zero_done k=%0d got %b want %b", k, done, (k == 4)); end
            if (k < 4) tick();
        end
        n_checks++; if (cyc !== CW'(3)) begin n_fail++; $display("FAIL zero_cyc got %0d want 3", cyc); end
        start = 1'b0;
        tick();
    endtask

    task automatic test_stall;
        int busy_n = 0;
        int done_k = 0;
        inst_num = NW'(8);
        start = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            if (busy) busy_n++;
            if (done && done_k == 0) done_k = k;
            if (k >= 4 && k <= 8) begin
                n_checks++; if (inst_addr !== AW'(3)) begin n_fail++; $display("FAIL stall_addr k=%0d got %0d want 3", k, inst_addr); end
            end
            if (k >= 5 && k <= 8) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy k=%0d got %b want 0", k, busy); end
                n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL stall_rd_en k=%0d got %b want 0", k, rd_en); end
            end
            if (k == 9) begin
                n_checks++; if (inst_addr !== AW'(4)) begin n_fail++; $display("FAIL stall_resume_addr got %0d want 4", inst_addr); end
            end
            stall = (k >= 4 && k <= 7);
            tick();
        end
        stall = 1'b0;
        n_checks++; if (busy_n != 13) begin n_fail++; $display("FAIL stall_busy_total got %0d want 13", busy_n); end
        n_checks++; if (done_k != 18) begin n_fail++; $display("FAIL stall_done_cycle got %0d want 18", done_k); end
        n_checks++; if (cyc !== CW'(13)) begin n_fail++; $display("FAIL stall_cyc got %0d want 13", cyc); end
    endtask

    task automatic test_handshake;
        int busy_n = 1;
        int done_k = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL hs_done_hold i=%0d got %b want 1", i, done); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_no_rerun i=%0d got %b want 0", i, busy); end
        end
        n_checks++; if (cyc !== CW'(13)) begin n_fail++; $display("FAIL hs_cyc_stable got %0d want 13", cyc); end
        start = 1'b0;
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL hs_done_fall got %b want 0", done); end
        inst_num = NW'(2);
        start = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hs_restart_busy got %b want 1", busy); end
        n_checks++; if (cyc !== '0) begin n_fail++; $display("FAIL hs_cyc_cleared got %0d want 0", cyc); end
        inst_num = NW'(900);
        for (int k = 2; k <= 12; k++) begin
            tick();
            if (busy) busy_n++;
            if (done && done_k == 0) done_k = k;
        end
        n_checks++; if (busy_n != 7) begin n_fail++; $display("FAIL hs_busy_total got %0d want 7", busy_n); end
        n_checks++; if (done_k != 8) begin n_fail++; $display("FAIL hs_done_cycle got %0d want 8", done_k); end
        n_checks++; if (cyc !== CW'(7)) begin n_fail++; $display("FAIL hs_cyc got %0d want 7", cyc); end
        start = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_run;
        int k = 1;
        int seen = 0;
        inst_num = NW'(20);
        start = 1'b1;
        tick();
        while (inst_addr !== AW'(6) && k < 30) begin
            tick();
            k++;
        end
        n_checks++; if (k != 7) begin n_fail++; $display("FAIL rst_reach_addr6 got cycle %0d want 7", k); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (inst_addr !== '0) begin n_fail++; $display("FAIL rst_mid_addr got %0d want 0", inst_addr); end
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd_en got %b want 0", rd_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_checks++; if (cyc !== '0) begin n_fail++; $display("FAIL rst_mid_cyc got %0d want 0", cyc); end
        start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done || busy) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_no_done got %0d active cycles want 0", seen); end
    endtask

    task automatic test_max_length;
        int busy_n = 0;
        int max_a = 0;
        int ea;
        s_inst_num = SNW'(16);
        s_start = 1'b1;
        tick();
        for (int k = 1; k <= 22; k++) begin
            ea = (k - 1 < 15) ? k - 1 : 15;
            if (s_busy) busy_n++;
            n_checks++; if (s_addr !== SAW'(ea)) begin n_fail++; $display("FAIL max_addr k=%0d got %0d want %0d", k, s_addr, ea); end
            if (k < 22) tick();
        end
        n_checks++; if (s_done !== 1'b1) begin n_fail++; $display("FAIL max_done got %b want 1", s_done); end
        n_checks++; if (busy_n != 21) begin n_fail++; $display("FAIL max_busy_total got %0d want 21", busy_n); end
        n_checks++; if (s_cyc !== CW'(21)) begin n_fail++; $display("FAIL max_cyc got %0d want 21", s_cyc); end
        s_start = 1'b0;
        repeat (2) tick();

        busy_n = 0;
        s_inst_num = SNW'(31);
        s_start = 1'b1;
        tick();
        for (int k = 1; k <= 30; k++) begin
            if (s_busy) busy_n++;
            if (int'(s_addr) > max_a) max_a = int'(s_addr);
            tick();
        end
        n_checks++; if (busy_n != 21) begin n_fail++; $display("FAIL clamp_busy_total got %0d want 21", busy_n); end
        n_checks++; if (s_cyc !== CW'(21)) begin n_fail++; $display("FAIL clamp_cyc got %0d want 21", s_cyc); end
        n_checks++; if (max_a != 15 || s_addr !== SAW'(15)) begin n_fail++; $display("FAIL clamp_addr got max %0d final %0d want 15", max_a, s_addr); end
        s_start = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_handshake();
        test_reset_mid_run();
        test_max_length();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
